// File: rtl/hc595_chain_driver.sv
// Serial driver for a daisy-chain of CHAIN 74HC595 devices: shifts one W-bit frame
// out on ds/sh_cp at clk/(2*CLK_DIV), then pulses st_cp once to latch it.
//
// state | meaning
// IDLE  | s_ready high, waiting for s_valid
// SHIFT | clocking bits out, sh_cp low then high for CLK_DIV cycles each
// LATCH | st_cp high for CLK_DIV cycles, done on exit
module hc595_chain_driver #(
  parameter int CHAIN     = 2,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [8*CHAIN-1:0] data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               sh_cp,
  output logic               st_cp,
  output logic               ds,
  output logic               busy,
  output logic               done
);

  localparam int W  = 8 * CHAIN;
  localparam int BW = $clog2(W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [DW-1:0] DIV_TC   = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DW-1:0]  div_cnt, div_cnt_nxt;
  logic [W-1:0]   shreg, shreg_nxt, shreg_adv;
  logic           sh_cp_nxt, st_cp_nxt, ds_nxt, s_ready_nxt, busy_nxt, done_nxt;
  logic           phase_end, last_bit;

  function automatic logic first_bit(input logic [W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[W-1];
  endfunction

  assign phase_end = (div_cnt == DIV_TC);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign shreg_adv = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = SHIFT;
      SHIFT:   if (phase_end && sh_cp && last_bit) state_nxt = LATCH;
      LATCH:   if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output; ds only moves when sh_cp falls.
  always_comb begin
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt + 1'b1;
    shreg_nxt   = shreg;
    sh_cp_nxt   = sh_cp;
    st_cp_nxt   = st_cp;
    ds_nxt      = ds;
    s_ready_nxt = s_ready;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (s_valid) begin
          shreg_nxt   = data;
          ds_nxt      = first_bit(data);
          sh_cp_nxt   = 1'b0;
          s_ready_nxt = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          div_cnt_nxt = '0;
          if (!sh_cp) begin
            sh_cp_nxt = 1'b1;
          end else begin
            sh_cp_nxt = 1'b0;
            if (last_bit) begin
              st_cp_nxt   = 1'b1;
              bit_cnt_nxt = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
              shreg_nxt   = shreg_adv;
              ds_nxt      = first_bit(shreg_adv);
            end
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          div_cnt_nxt = '0;
          st_cp_nxt   = 1'b0;
          done_nxt    = 1'b1;
          s_ready_nxt = 1'b1;
          busy_nxt    = 1'b0;
        end
      end
      default: begin
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      div_cnt <= '0;
      shreg   <= '0;
      sh_cp   <= 1'b0;
      st_cp   <= 1'b0;
      ds      <= 1'b0;
      s_ready <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      shreg   <= shreg_nxt;
      sh_cp   <= sh_cp_nxt;
      st_cp   <= st_cp_nxt;
      ds      <= ds_nxt;
      s_ready <= s_ready_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Parametrised serial driver for a daisy-chain of CHAIN 74HC595 shift registers, successor to the fixed 16-bit hc595_driver. It takes a parallel word through a valid/ready handshake, shifts it out MSB- or LSB-first at a programmable shift-clock rate, then pulses the storage clock once per frame. It sits between the display/LED scan logic and the board pins (sh_cp, st_cp, ds).

## Interface
- CHAIN, 2: number of cascaded 74HC595 devices; frame width W = 8*CHAIN, CHAIN ≥ 1
- CLK_DIV, 2: clk cycles per sh_cp half-period (D); CLK_DIV ≥ 1
- LSB_FIRST, 0: 0 = data[W-1] shifted first, 1 = data[0] shifted first

- clk  in  1  system clock (50 MHz on the board)
- reset_n  in  1  asynchronous, active-low reset
- data  in  W  word to send; sampled only on an accepted handshake
- s_valid  in  1  request to send data
- s_ready  out  1  driver idle, will accept on this cycle
- sh_cp  out  1  shift clock to 74HC595 SHCP
- st_cp  out  1  storage/latch clock to 74HC595 STCP
- ds  out  1  serial data to first 74HC595 DS
- busy  out  1  frame in progress (= ~s_ready)
- done  out  1  one-cycle pulse at end of each frame

## Operation
- All outputs are registered. During reset: sh_cp=0, st_cp=0, ds=0, s_ready=1, busy=0, done=0, and the FSM is in IDLE.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: s_ready=1. On s_valid && s_ready, capture data into the internal W-bit shift register, clear the bit counter, and go to SHIFT. In the same edge, drive ds = first bit and sh_cp=0.
- SHIFT: for each bit, sh_cp is low for D cycles, then high for D cycles. ds changes only on the edge that drives sh_cp low, so it is stable for D cycles before each rising edge and D cycles after. After the W-th high phase, go to LATCH with sh_cp=0.
- LATCH: st_cp is high for D cycles. On the edge that drops st_cp, assert done for one cycle, set s_ready=1, and return to IDLE. ds holds its last bit until the next frame.
- Bit order: LSB_FIRST=0 sends data[W-1] down to data[0]. LSB_FIRST=1 sends data[0] up to data[W-1]. The last bit shifted lands in the Q0 position of device nearest ds... for MSB-first, data[7:0] lands in the first device.
- data and s_valid are ignored outside an accepted handshake. Changes to data mid-frame do not affect the frame in progress.
- Counters: bit counter is clog2(W+1) bits, divider counter is clog2(CLK_DIV+1) bits. Both are cleared on every state entry, and neither wraps within a frame.
- Reset mid-frame aborts immediately with all outputs at reset values. No st_cp pulse is issued, so the 74HC595 outputs keep the last latched frame.

## Timing
- Cycle 0 is the accepting edge.
- Bit k (k = 0..W-1): sh_cp low over cycles [2kD, 2kD+D) and high over [2kD+D, 2kD+2D). The rising edge is at cycle 2kD+D.
- st_cp rises at cycle 2WD and falls at cycle (2W+1)D.
- done=1 and s_ready=1 in cycle (2W+1)D.
- The earliest next accept is at cycle (2W+1)D+1. With s_valid held high, the frame period is (2W+1)D+1 cycles.
- Defaults (W=16, D=2): 16 sh_cp rises, st_cp high for cycles 64–65, done at cycle 66, period 67 cycles (1.34 µs at 50 MHz).
- sh_cp frequency is f_clk/(2D); at D=1 it is 25 MHz.

## Test plan
- Reset: hold reset_n=0 for 20 cycles with s_valid=1. All outputs stay at their reset values. After release, the first accept happens on the next edge.
- Defaults, data=16'hAF65, single pulse of s_valid:
  - ds sampled at sh_cp rising edges reads 1010_1111_0110_0101.
  - There are exactly 16 rises, followed by one 2-cycle st_cp pulse.
  - done appears at cycle 66, and s_ready is low over cycles 1–65.
- Mid-frame change: data changes to 16'h55A5 at cycle 10 with s_valid held. Frame 1 shifts AF65 and frame 2 shifts 55A5. The frame-2 accept happens at cycle 67.
- Back-to-back with s_valid=1 for 5 frames: st_cp pulses are 67 cycles apart, and there are no glitches on sh_cp or st_cp between frames.
- CHAIN=3, CLK_DIV=1, LSB_FIRST=1, data=24'h123456: the ds sequence is data[0]..data[23] (0,1,1,0,1,0,1,0,…), 24 rises, done at cycle 49.
- Reset asserted at cycle 30 of a default frame:
  - sh_cp, st_cp and ds go to 0 immediately, and no st_cp pulse occurs.
  - After release, a new frame with 16'h1234 completes normally, with done at cycle 66.
